// File: rtl/uart_pixel_framer_if.sv
// rtl/uart_pixel_framer_if.sv - byte input and pixel output bundle for uart_pixel_framer
interface uart_pixel_framer_if #(
    parameter int CHANNELS = 1
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic [8*CHANNELS-1:0] pix_data;
    logic                  pix_valid;
    logic                  pix_ready;
    logic                  pix_sof;
    logic                  pix_eol;
    logic                  pix_eof;

    modport master (
        output rx_data, rx_valid, pix_ready,
        input  pix_data, pix_valid, pix_sof, pix_eol, pix_eof
    );

    modport slave (
        input  rx_data, rx_valid, pix_ready,
        output pix_data, pix_valid, pix_sof, pix_eol, pix_eof
    );
endinterface

// File: rtl/uart_pixel_framer.sv
// rtl/uart_pixel_framer.sv - sync-hunting byte-to-pixel framer with geometry tags and pixel FIFO
module uart_pixel_framer #(
    parameter int         WIDTH      = 512,
    parameter int         HEIGHT     = 512,
    parameter int         CHANNELS   = 1,
    parameter int         FIFO_DEPTH = 16,
    parameter int         TIMEOUT    = 50000,
    parameter logic [7:0] SYNC0      = 8'hA5,
    parameter logic [7:0] SYNC1      = 8'h5A
) (
    input  logic                clk,
    input  logic                rst,
    uart_pixel_framer_if.slave  bus,
    output logic                busy,
    output logic                err_overrun,
    output logic                err_timeout,
    input  logic                err_clr
);
    localparam int PW = 8 * CHANNELS;
    localparam int EW = PW + 3;
    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(TIMEOUT + 1);

    localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(CHANNELS - 1);
    localparam logic [IW-1:0] I_LAST   = IW'(TIMEOUT - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        HUNT0   = 2'd0,
        HUNT1   = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t        r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [BW-1:0] r_bidx;
    logic [PW-1:0] r_pack;
    logic [IW-1:0] r_idle;
    logic          r_overrun;
    logic          r_timeout;

    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic [PW-1:0] w_pixel;
    logic [EW-1:0] w_head;
    logic          w_complete;
    logic          w_sof;
    logic          w_eol;
    logic          w_eof;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_abort;

    // The completing byte goes straight into the pushed word, so a pixel is visible one cycle later.
    always_comb begin
        w_pixel = r_pack;
        for (int l = 0; l < CHANNELS; l++) begin
            if (r_bidx == BW'(l)) begin
                w_pixel[8*l +: 8] = bus.rx_data;
            end
        end
    end

    assign w_complete = bus.rx_valid && (r_state == PAYLOAD) && (r_bidx == B_LAST);
    assign w_sof      = (r_x == '0) && (r_y == '0);
    assign w_eol      = (r_x == X_LAST);
    assign w_eof      = w_eol && (r_y == Y_LAST);

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = !w_empty && bus.pix_ready;
    assign w_push  = w_complete && (!w_full || w_pop);
    assign w_drop  = w_complete && w_full && !w_pop;
    assign w_abort = !bus.rx_valid && (r_state != HUNT0) && (r_idle == I_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HUNT0;
            r_x     <= '0;
            r_y     <= '0;
            r_bidx  <= '0;
            r_pack  <= '0;
            r_idle  <= '0;
        end else begin
            if (bus.rx_valid || (r_state == HUNT0) || w_abort) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + 1'b1;
            end

            case (r_state)
                HUNT0: begin
                    if (bus.rx_valid && (bus.rx_data == SYNC0)) begin
                        r_state <= HUNT1;
                    end
                end
                HUNT1: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == SYNC1) begin
                            r_state <= PAYLOAD;
                            r_x     <= '0;
                            r_y     <= '0;
                            r_bidx  <= '0;
                        end else if (bus.rx_data != SYNC0) begin
                            r_state <= HUNT0;
                        end
                    end else if (w_abort) begin
                        r_state <= HUNT0;
                    end
                end
                PAYLOAD: begin
                    if (bus.rx_valid) begin
                        r_pack <= w_pixel;
                        if (r_bidx == B_LAST) begin
                            // Geometry advances even for a dropped pixel so later tags stay aligned.
                            r_bidx <= '0;
                            if (w_eol) begin
                                r_x <= '0;
                                r_y <= r_y + 1'b1;
                                if (w_eof) begin
                                    r_state <= HUNT0;
                                end
                            end else begin
                                r_x <= r_x + 1'b1;
                            end
                        end else begin
                            r_bidx <= r_bidx + 1'b1;
                        end
                    end else if (w_abort) begin
                        r_state <= HUNT0;
                        r_bidx  <= '0;
                    end
                end
                default: begin
                    r_state <= HUNT0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_eof, w_eol, w_sof, w_pixel};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A new error event outranks a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end
            if (w_abort) begin
                r_timeout <= 1'b1;
            end else if (err_clr) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign w_head = r_mem[r_rptr];

    assign bus.pix_valid = !w_empty;
    assign bus.pix_data  = w_empty ? '0 : w_head[PW-1:0];
    assign bus.pix_sof   = !w_empty && w_head[PW];
    assign bus.pix_eol   = !w_empty && w_head[PW+1];
    assign bus.pix_eof   = !w_empty && w_head[PW+2];

    assign busy        = (r_state != HUNT0) || !w_empty;
    assign err_overrun = r_overrun;
    assign err_timeout = r_timeout;
endmodule

// File: tb/tb_uart_pixel_framer.sv
// tb/tb_uart_pixel_framer.sv - directed and randomized checks of uart_pixel_framer against a frame model
module tb_uart_pixel_framer;
    localparam int W = 4;
    localparam int H = 2;
    localparam int C = 3;
    localparam int D = 4;
    localparam int T = 100;

    logic clk;
    logic rst;
    logic busy;
    logic err_overrun;
    logic err_timeout;
    logic err_clr;

    int n_vec;
    int n_err;
    bit use_model;
    bit rand_ready;

    logic [26:0] exp_q[$];
    logic [26:0] obs_q[$];

    int          m_mode;
    int          m_bytes;
    int          m_pix;
    logic [23:0] m_acc;

    uart_pixel_framer_if #(.CHANNELS(C)) bus ();

    uart_pixel_framer #(
        .WIDTH(W), .HEIGHT(H), .CHANNELS(C), .FIFO_DEPTH(D), .TIMEOUT(T),
        .SYNC0(8'hA5), .SYNC1(8'h5A)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .busy(busy),
        .err_overrun(err_overrun),
        .err_timeout(err_timeout),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired before the end of the sequence");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame model: linear pixel index within the frame decides the tags.
    task automatic model_byte(input logic [7:0] b);
        logic sof, eol, eof;
        case (m_mode)
            0: if (b == 8'hA5) m_mode = 1;
            1: begin
                if (b == 8'h5A) begin
                    m_mode  = 2;
                    m_bytes = 0;
                    m_pix   = 0;
                end else if (b != 8'hA5) begin
                    m_mode = 0;
                end
            end
            default: begin
                m_acc[8*m_bytes +: 8] = b;
                m_bytes++;
                if (m_bytes == C) begin
                    sof = (m_pix == 0);
                    eol = ((m_pix % W) == W - 1);
                    eof = (m_pix == W * H - 1);
                    exp_q.push_back({eof, eol, sof, m_acc});
                    m_pix++;
                    m_bytes = 0;
                    if (eof) m_mode = 0;
                end
            end
        endcase
    endtask

    task automatic model_abort();
        m_mode  = 0;
        m_bytes = 0;
    endtask

    task automatic cycle(input logic v, input logic [7:0] d);
        logic [26:0] head;
        logic [26:0] e;
        bus.rx_valid = v;
        bus.rx_data  = d;
        if (rand_ready) bus.pix_ready = ($urandom_range(3) != 0);
        @(negedge clk);
        if (bus.pix_valid && bus.pix_ready) begin
            head = {bus.pix_eof, bus.pix_eol, bus.pix_sof, bus.pix_data};
            obs_q.push_back(head);
            if (use_model) begin
                chk("pixel_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pixel", 32'(head), 32'(e));
                end
            end
        end
        if (v) model_byte(d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'h00);
    endtask

    task automatic send_frame(input int gmin, input int gmax);
        cycle(1'b1, 8'hA5);
        idle($urandom_range(gmax, gmin));
        cycle(1'b1, 8'h5A);
        for (int i = 0; i < W * H * C; i++) begin
            idle($urandom_range(gmax, gmin));
            cycle(1'b1, 8'($urandom));
        end
    endtask

    initial begin
        logic [26:0] e;
        int k;
        clk = 1'b0;
        rst = 1'b1;
        err_clr = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.pix_ready = 1'b1;
        n_vec = 0;
        n_err = 0;
        use_model  = 1'b1;
        rand_ready = 1'b0;
        m_mode = 0; m_bytes = 0; m_pix = 0; m_acc = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pix_valid", bus.pix_valid, 0);
        chk("rst_pix_sof", bus.pix_sof, 0);
        chk("rst_pix_eol", bus.pix_eol, 0);
        chk("rst_pix_eof", bus.pix_eof, 0);
        chk("rst_pix_data", bus.pix_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_overrun", err_overrun, 0);
        chk("rst_err_timeout", err_timeout, 0);
        rst = 1'b0;

        // Back-to-back frame with bytes 00..17.
        obs_q.delete();
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h5A);
        for (int i = 0; i < 24; i++) begin
            cycle(1'b1, 8'(i));
            if (i == 1) chk("latency_before", bus.pix_valid, 0);
            if (i == 2) chk("latency_valid", bus.pix_valid, 1);
        end
        idle(6);
        chk("t1_count", obs_q.size(), 8);
        if (obs_q.size() == 8) begin
            chk("t1_pix1", 32'(obs_q[0]), {5'd0, 3'b001, 24'h020100});
            chk("t1_pix4", 32'(obs_q[3]), {5'd0, 3'b010, 24'h0B0A09});
            chk("t1_pix8", 32'(obs_q[7]), {5'd0, 3'b110, 24'h171615});
        end
        chk("t1_busy", busy, 0);
        chk("t1_model_drained", exp_q.size(), 0);

        // Header hunting through noise and repeated SYNC0.
        obs_q.delete();
        cycle(1'b1, 8'h11);
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h5A);
        for (int i = 0; i < 24; i++) cycle(1'b1, 8'($urandom));
        idle(6);
        chk("hunt_count", obs_q.size(), 8);
        chk("hunt_model_drained", exp_q.size(), 0);
        obs_q.delete();
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h00);
        cycle(1'b1, 8'h5A);
        for (int i = 1; i <= 6; i++) cycle(1'b1, 8'(i));
        idle(4);
        chk("broken_header_count", obs_q.size(), 0);
        chk("broken_header_busy", busy, 0);

        // Overrun with a stalled consumer.
        use_model = 1'b0;
        bus.pix_ready = 1'b0;
        obs_q.delete();
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h5A);
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < 3; c++) begin
                if (p == 5 && c == 2) err_clr = 1'b1;
                cycle(1'b1, 8'(8'h40 + 3 * p + c));
                err_clr = 1'b0;
            end
            if (p == 3) chk("no_overrun_at_fill", err_overrun, 0);
            if (p == 4) chk("overrun_set", err_overrun, 1);
            if (p == 5) chk("set_beats_clr", err_overrun, 1);
        end
        bus.pix_ready = 1'b1;
        idle(8);
        chk("overrun_kept", obs_q.size(), 4);
        if (obs_q.size() == 4) begin
            for (int q = 0; q < 4; q++) begin
                e = {1'b0, q == 3, q == 0, 8'(8'h42 + 3 * q), 8'(8'h41 + 3 * q), 8'(8'h40 + 3 * q)};
                chk("overrun_pix", 32'(obs_q[q]), 32'(e));
            end
        end
        chk("overrun_busy", busy, 0);
        err_clr = 1'b1;
        cycle(1'b0, 8'h00);
        err_clr = 1'b0;
        chk("overrun_clr", err_overrun, 0);
        exp_q.delete();
        use_model = 1'b1;

        // Full FIFO with a pop in the completion cycle.
        bus.pix_ready = 1'b0;
        obs_q.delete();
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h5A);
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < 3; c++) begin
                if (p == 4 && c == 2) bus.pix_ready = 1'b1;
                cycle(1'b1, 8'($urandom));
                if (p == 4 && c == 2) begin
                    chk("push_pop_at_full", err_overrun, 0);
                    bus.pix_ready = 1'b0;
                    cycle(1'b0, 8'h00);
                    chk("push_pop_still_full", bus.pix_valid, 1);
                    bus.pix_ready = 1'b1;
                end
            end
        end
        idle(8);
        chk("push_pop_count", obs_q.size(), 8);
        chk("push_pop_overrun", err_overrun, 0);

        // Idle timeout mid-frame.
        obs_q.delete();
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h5A);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom));
        k = 0;
        while (!err_timeout && k < 300) begin
            cycle(1'b0, 8'h00);
            k++;
        end
        chk("timeout_cycles", k, T);
        chk("timeout_busy", busy, 0);
        chk("timeout_pixels", obs_q.size(), 1);
        model_abort();
        send_frame(0, 2);
        idle(8);
        chk("after_timeout_drained", exp_q.size(), 0);
        chk("after_timeout_count", obs_q.size(), 9);
        err_clr = 1'b1;
        cycle(1'b0, 8'h00);
        err_clr = 1'b0;
        chk("timeout_clr", err_timeout, 0);

        // Reset in the middle of a frame.
        bus.pix_ready = 1'b0;
        obs_q.delete();
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h5A);
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'($urandom));
        chk("pre_rst_valid", bus.pix_valid, 1);
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", bus.pix_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", bus.pix_data, 0);
        rst = 1'b0;
        exp_q.delete();
        model_abort();
        bus.pix_ready = 1'b1;
        send_frame(0, 1);
        idle(8);
        chk("post_rst_count", obs_q.size(), 8);
        if (obs_q.size() != 0) chk("post_rst_sof", 32'(obs_q[0][24]), 1);

        // Randomized frames with noise, gaps and a bursty consumer.
        rand_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            for (int n = 0; n < int'($urandom_range(3)); n++) cycle(1'b1, 8'($urandom));
            idle(1);
            send_frame(1, 3);
        end
        rand_ready = 1'b0;
        bus.pix_ready = 1'b1;
        idle(10);
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_overrun", err_overrun, 0);
        chk("rand_timeout", err_timeout, 0);
        chk("rand_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
